// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, control-field
// widths, bit positions within each field, and the decoded control bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  // WB = {RegWrite, MemtoReg}, M = {Branch, MemRead, MemWrite},
  // EX = {RegDst, ALUOp[1:0], ALUSrc}
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;
  localparam int REGDST   = 3;
  localparam int ALUOP_HI = 2;
  localparam int ALUOP_LO = 1;
  localparam int ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
    logic            bne;
    logic            illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Purely combinational opcode decoder producing the WB/M/EX control bundle.
// Also usable by the single-cycle datapath.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int EXT_OPS = 0
) (
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.wb[REGWRITE] = 1'b1;
        o_ctrl.ex[REGDST]   = 1'b1;
        o_ctrl.ex[ALUOP_HI] = 1'b1;
      end
      OP_LW: begin
        o_ctrl.wb[REGWRITE] = 1'b1;
        o_ctrl.wb[MEMTOREG] = 1'b1;
        o_ctrl.m[MEMREAD]   = 1'b1;
        o_ctrl.ex[ALUSRC]   = 1'b1;
      end
      OP_SW: begin
        o_ctrl.m[MEMWRITE]  = 1'b1;
        o_ctrl.ex[ALUSRC]   = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.m[BRANCH]    = 1'b1;
        o_ctrl.ex[ALUOP_LO] = 1'b1;
      end
      // Extended opcodes fall back to "undecodable" when not enabled
      OP_ADDI: begin
        if (EXT_OPS != 0) begin
          o_ctrl.wb[REGWRITE] = 1'b1;
          o_ctrl.ex[ALUSRC]   = 1'b1;
        end else begin
          o_ctrl.illegal = 1'b1;
        end
      end
      OP_BNE: begin
        if (EXT_OPS != 0) begin
          o_ctrl.m[BRANCH]    = 1'b1;
          o_ctrl.ex[ALUOP_LO] = 1'b1;
          o_ctrl.bne          = 1'b1;
        end else begin
          o_ctrl.illegal = 1'b1;
        end
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the IF/ID opcode, carries control fields
// through ID/EX, EX/MEM and MEM/WB, inserts load-use bubbles and applies flushes.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int EXT_OPS   = 0,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              flush,
  output logic              stall,
  output logic              illegal,
  output logic [EX_W-1:0]   ex_ex,
  output logic [M_W-1:0]    m_ex,
  output logic [WB_W-1:0]   wb_ex,
  output logic [M_W-1:0]    m_mem,
  output logic [WB_W-1:0]   wb_mem,
  output logic [WB_W-1:0]   wb_wb,
  output logic              bne_mem
);

  ctrl_t             w_dec;
  logic              w_stall;

  logic [REG_AW-1:0] r_id_ex_rt;
  logic [EX_W-1:0]   r_ex_ex;
  logic [M_W-1:0]    r_m_ex;
  logic [WB_W-1:0]   r_wb_ex;
  logic              r_illegal;
  logic              r_bne_ex;
  logic [M_W-1:0]    r_m_mem;
  logic [WB_W-1:0]   r_wb_mem;
  logic              r_bne_mem;
  logic [WB_W-1:0]   r_wb_wb;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .i_opcode (opcode),
    .o_ctrl   (w_dec)
  );

  // Register 0 is deliberately not exempt from the comparison
  assign w_stall = (HAZARD_EN != 0) && r_m_ex[MEMREAD] &&
                   ((r_id_ex_rt == if_id_rs) || (r_id_ex_rt == if_id_rt));

  // ID/EX: flush beats stall; both turn the slot into a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_ex_rt <= '0;
      r_ex_ex    <= '0;
      r_m_ex     <= '0;
      r_wb_ex    <= '0;
      r_illegal  <= 1'b0;
      r_bne_ex   <= 1'b0;
    end else begin
      r_id_ex_rt <= if_id_rt;
      if (flush || w_stall) begin
        r_ex_ex   <= '0;
        r_m_ex    <= '0;
        r_wb_ex   <= '0;
        r_illegal <= 1'b0;
        r_bne_ex  <= 1'b0;
      end else begin
        r_ex_ex   <= w_dec.ex;
        r_m_ex    <= w_dec.m;
        r_wb_ex   <= w_dec.wb;
        r_illegal <= w_dec.illegal;
        r_bne_ex  <= w_dec.bne;
      end
    end
  end

  // EX/MEM
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_m_mem   <= '0;
      r_wb_mem  <= '0;
      r_bne_mem <= 1'b0;
    end else begin
      r_m_mem   <= r_m_ex;
      r_wb_mem  <= r_wb_ex;
      r_bne_mem <= r_bne_ex;
    end
  end

  // MEM/WB: the instruction already in MEM is older than the branch and survives a flush
  always_ff @(posedge clk) begin
    if (rst) r_wb_wb <= '0;
    else     r_wb_wb <= r_wb_mem;
  end

  assign stall   = w_stall;
  assign illegal = r_illegal;
  assign ex_ex   = r_ex_ex;
  assign m_ex    = r_m_ex;
  assign wb_ex   = r_wb_ex;
  assign m_mem   = r_m_mem;
  assign wb_mem  = r_wb_mem;
  assign wb_wb   = r_wb_wb;
  assign bne_mem = r_bne_mem;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: three configurations driven in parallel, checked every
// cycle against an instruction-level pipeline model plus literal expectations.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] if_rs, if_rt;
  logic       flush;

  always #5 clk = ~clk;

  // cfg0: base (EXT_OPS=0, HAZARD_EN=1); cfg1: EXT_OPS=1; cfg2: HAZARD_EN=0
  logic b_stall, b_ill, b_bne_mem;
  logic [3:0] b_ex_ex; logic [2:0] b_m_ex, b_m_mem; logic [1:0] b_wb_ex, b_wb_mem, b_wb_wb;
  logic e_stall, e_ill, e_bne_mem;
  logic [3:0] e_ex_ex; logic [2:0] e_m_ex, e_m_mem; logic [1:0] e_wb_ex, e_wb_mem, e_wb_wb;
  logic n_stall, n_ill, n_bne_mem;
  logic [3:0] n_ex_ex; logic [2:0] n_m_ex, n_m_mem; logic [1:0] n_wb_ex, n_wb_mem, n_wb_wb;

  ctrl_pipe #(.REG_AW(5), .EXT_OPS(0), .HAZARD_EN(1)) u_base (
    .clk(clk), .rst(rst), .opcode(opcode), .if_id_rs(if_rs), .if_id_rt(if_rt), .flush(flush),
    .stall(b_stall), .illegal(b_ill), .ex_ex(b_ex_ex), .m_ex(b_m_ex), .wb_ex(b_wb_ex),
    .m_mem(b_m_mem), .wb_mem(b_wb_mem), .wb_wb(b_wb_wb), .bne_mem(b_bne_mem));

  ctrl_pipe #(.REG_AW(5), .EXT_OPS(1), .HAZARD_EN(1)) u_ext (
    .clk(clk), .rst(rst), .opcode(opcode), .if_id_rs(if_rs), .if_id_rt(if_rt), .flush(flush),
    .stall(e_stall), .illegal(e_ill), .ex_ex(e_ex_ex), .m_ex(e_m_ex), .wb_ex(e_wb_ex),
    .m_mem(e_m_mem), .wb_mem(e_wb_mem), .wb_wb(e_wb_wb), .bne_mem(e_bne_mem));

  ctrl_pipe #(.REG_AW(5), .EXT_OPS(0), .HAZARD_EN(0)) u_nohz (
    .clk(clk), .rst(rst), .opcode(opcode), .if_id_rs(if_rs), .if_id_rt(if_rt), .flush(flush),
    .stall(n_stall), .illegal(n_ill), .ex_ex(n_ex_ex), .m_ex(n_m_ex), .wb_ex(n_wb_ex),
    .m_mem(n_m_mem), .wb_mem(n_wb_mem), .wb_wb(n_wb_wb), .bne_mem(n_bne_mem));

  logic [18:0] got [3];
  assign got[0] = {b_stall, b_ill, b_ex_ex, b_m_ex, b_wb_ex, b_m_mem, b_wb_mem, b_wb_wb, b_bne_mem};
  assign got[1] = {e_stall, e_ill, e_ex_ex, e_m_ex, e_wb_ex, e_m_mem, e_wb_mem, e_wb_wb, e_bne_mem};
  assign got[2] = {n_stall, n_ill, n_ex_ex, n_m_ex, n_wb_ex, n_m_mem, n_wb_mem, n_wb_wb, n_bne_mem};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, BNE = 6'b000101, BAD = 6'b111111;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mdl_ok = 1'b0;

  // Model: which instruction (if any) occupies each stage, per configuration
  bit         ex_v [3], mem_v [3], wb_v [3];
  logic [5:0] ex_op [3], mem_op [3], wb_op [3];
  logic [4:0] ex_rt [3];

  function automatic bit cfg_ext(int k); return (k == 1); endfunction
  function automatic bit cfg_hz(int k);  return (k != 2); endfunction

  // {wb[1:0], m[2:0], ex[3:0], bne, illegal}
  function automatic logic [10:0] dec(logic [5:0] op, bit ext);
    case (op)
      6'b000000: return {2'b10, 3'b000, 4'b1100, 1'b0, 1'b0};
      6'b100011: return {2'b11, 3'b010, 4'b0001, 1'b0, 1'b0};
      6'b101011: return {2'b00, 3'b001, 4'b0001, 1'b0, 1'b0};
      6'b000100: return {2'b00, 3'b100, 4'b0010, 1'b0, 1'b0};
      6'b001000: return ext ? {2'b10, 3'b000, 4'b0001, 1'b0, 1'b0} : 11'b1;
      6'b000101: return ext ? {2'b00, 3'b100, 4'b0010, 1'b1, 1'b0} : 11'b1;
      default:   return 11'b1;
    endcase
  endfunction

  function automatic bit exp_stall(int k);
    return cfg_hz(k) && ex_v[k] && (ex_op[k] == 6'b100011) &&
           ((ex_rt[k] == if_rs) || (ex_rt[k] == if_rt));
  endfunction

  function automatic logic [18:0] expect_out(int k);
    logic [10:0] de, dm, dw;
    de = ex_v[k]  ? dec(ex_op[k],  cfg_ext(k)) : 11'd0;
    dm = mem_v[k] ? dec(mem_op[k], cfg_ext(k)) : 11'd0;
    dw = wb_v[k]  ? dec(wb_op[k],  cfg_ext(k)) : 11'd0;
    return {exp_stall(k), de[0], de[5:2], de[8:6], de[10:9], dm[8:6], dm[10:9], dw[10:9], dm[1]};
  endfunction

  task automatic compare_all();
    if (mdl_ok) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got[k] !== expect_out(k)) begin
          n_err++;
          $display("FAIL model cfg%0d cycle %0d: got %05h expected %05h", k, cyc, got[k], expect_out(k));
        end
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit st;
      st = exp_stall(k);
      if (rst) begin
        ex_v[k] = 1'b0; mem_v[k] = 1'b0; wb_v[k] = 1'b0;
      end else begin
        wb_v[k]  = mem_v[k];           wb_op[k]  = mem_op[k];
        mem_v[k] = ex_v[k] && !flush;  mem_op[k] = ex_op[k];
        ex_v[k]  = !(flush || st);     ex_op[k]  = opcode;  ex_rt[k] = if_rt;
      end
    end
    if (rst) mdl_ok = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs_i, input logic [4:0] rt_i,
                       input logic fl);
    opcode = op; if_rs = rs_i; if_rt = rt_i; flush = fl;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, g, e);
    end
  endtask

  logic [5:0] tbl_op [10];
  logic [4:0] tbl_rs [10];
  logic [4:0] tbl_rt [10];
  logic       tbl_fl [10];

  initial begin
    rst = 1'b1;
    drive(RT, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    chk("reset_base", {13'd0, got[0]}, 32'd0);
    chk("reset_ext",  {13'd0, got[1]}, 32'd0);

    rst = 1'b0;
    drive(RT, 5'd1, 5'd2, 1'b0); tick();
    chk("rtype_ex", {b_ex_ex, b_m_ex, b_wb_ex}, {4'b1100, 3'b000, 2'b10});
    drive(SW, 5'd0, 5'd0, 1'b0); tick();
    tick();
    chk("rtype_wb", b_wb_wb, 2'b10);

    // Load-use with rs match
    drive(LW, 5'd0, 5'd5, 1'b0); tick();
    drive(RT, 5'd5, 5'd6, 1'b0);
    chk("lu_stall", b_stall, 1);
    chk("lu_stall_nohz", n_stall, 0);
    tick();
    chk("lu_bubble", {b_ex_ex, b_m_ex, b_wb_ex}, 0);
    chk("lu_stall_clear", b_stall, 0);
    tick();
    chk("lu_resume", {b_ex_ex, b_m_ex, b_wb_ex}, {4'b1100, 3'b000, 2'b10});

    // No register match
    drive(LW, 5'd0, 5'd5, 1'b0); tick();
    drive(RT, 5'd3, 5'd7, 1'b0);
    chk("no_match", b_stall, 0);
    tick();

    // Hazard detection disabled
    drive(LW, 5'd0, 5'd5, 1'b0); tick();
    drive(RT, 5'd5, 5'd9, 1'b0);
    chk("hz_off", n_stall, 0);
    chk("hz_on", b_stall, 1);
    tick(); tick();

    // sw, beq, undecodable
    drive(SW, 5'd0, 5'd0, 1'b0); tick();
    chk("sw_m", b_m_ex, 3'b001);
    chk("sw_ill", b_ill, 0);
    drive(BEQ, 5'd0, 5'd0, 1'b0); tick();
    chk("beq_m", b_m_ex, 3'b100);
    drive(BAD, 5'd0, 5'd0, 1'b0); tick();
    chk("bad_m", b_m_ex, 3'b000);
    chk("bad_ill", b_ill, 1);

    // Extended opcodes
    drive(ADDI, 5'd0, 5'd0, 1'b0); tick();
    chk("addi_ext", {e_ex_ex, e_wb_ex}, {4'b0001, 2'b10});
    chk("addi_base_ill", b_ill, 1);
    chk("addi_base_fields", {b_ex_ex, b_m_ex, b_wb_ex}, 0);
    drive(BNE, 5'd0, 5'd0, 1'b0); tick();
    drive(RT, 5'd1, 5'd2, 1'b0); tick();
    chk("bne_mem_ext", e_bne_mem, 1);
    chk("bne_mem_base", b_bne_mem, 0);

    // Flush with lw in ID/EX and R-type in ID
    drive(LW, 5'd0, 5'd8, 1'b0); tick();
    drive(RT, 5'd1, 5'd2, 1'b1); tick();
    chk("flush_m_mem", b_m_mem, 3'b000);
    chk("flush_ex_ex", b_ex_ex, 4'b0000);

    // Flush and stall together
    drive(LW, 5'd0, 5'd5, 1'b0); tick();
    drive(RT, 5'd5, 5'd1, 1'b1);
    chk("fs_stall", b_stall, 1);
    tick();
    chk("fs_ex", {b_ex_ex, b_m_ex, b_wb_ex}, 0);
    chk("fs_mem", b_m_mem, 0);

    // Reset in the middle of a full pipeline
    drive(LW, 5'd0, 5'd4, 1'b0); tick();
    drive(RT, 5'd1, 5'd2, 1'b0); tick();
    rst = 1'b1;
    drive(SW, 5'd0, 5'd0, 1'b0); tick();
    chk("midrst_base", {13'd0, got[0]}, 32'd0);
    chk("midrst_ext",  {13'd0, got[1]}, 32'd0);
    chk("midrst_nohz", {13'd0, got[2]}, 32'd0);
    rst = 1'b0;

    // Mixed directed sequence, checked by the model only
    tbl_op = '{LW, RT, SW, LW, SW, BNE, ADDI, BEQ, BAD, RT};
    tbl_rs = '{5'd0, 5'd9, 5'd2, 5'd0, 5'd3, 5'd0, 5'd0, 5'd1, 5'd0, 5'd4};
    tbl_rt = '{5'd9, 5'd1, 5'd3, 5'd3, 5'd6, 5'd0, 5'd7, 5'd2, 5'd0, 5'd5};
    tbl_fl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl_op[i], tbl_rs[i], tbl_rt[i], tbl_fl[i]);
      tick();
    end
    drive(RT, 5'd0, 5'd0, 1'b0);
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
